// File: rtl/io_pwr_pkg.sv
// io_pwr_pkg: state encoding, pad-control bundle and default timing for the IO power sequencer
package io_pwr_pkg;
  typedef enum logic [3:0] {
    OFF, WAIT_PG, DEBOUNCE, RET_REL, RX_EN, DRV_EN, ON, SHUT_DRV, SHUT_RX, FAULT
  } pwr_state_e;
  typedef struct packed {
    logic ret;
    logic rx_en;
    logic drv_en;
    logic ready;
    logic fault;
  } pad_ctrl_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES = 64;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_CNT_W = 13;
  function automatic pad_ctrl_t decode(pwr_state_e s);
    pad_ctrl_t p;
    p.ret = s inside {OFF, WAIT_PG, DEBOUNCE, FAULT};
    p.rx_en = s inside {RX_EN, DRV_EN, ON, SHUT_DRV};
    p.drv_en = s inside {DRV_EN, ON};
    p.ready = s == ON;
    p.fault = s == FAULT;
    return p;
  endfunction
endpackage

// File: rtl/io_pwr_seq_ctrl_if.sv
// io_pwr_seq_ctrl_if: PMU request/status and IO pad ring control nets of the power sequencer
interface io_pwr_seq_ctrl_if;
  logic pg_async;
  logic req_on;
  logic clr_fault;
  logic io_ret;
  logic io_rx_en;
  logic io_drv_en;
  logic io_ready;
  logic fault;
  logic [3:0] state_o;
  modport master (
    input pg_async, req_on, clr_fault,
    output io_ret, io_rx_en, io_drv_en, io_ready, fault, state_o
  );
  modport slave (
    output pg_async, req_on, clr_fault,
    input io_ret, io_rx_en, io_drv_en, io_ready, fault, state_o
  );
endinterface

// File: rtl/io_pwr_sync.sv
// io_pwr_sync: multi-flop synchroniser with synchronous active-low reset
module io_pwr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk)
    sync_q <= !rst_n ? '0 : {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/io_pwr_seq_ctrl.sv
// io_pwr_seq_ctrl: debounces IO power-good and sequences pad retention, receiver and driver enables
module io_pwr_seq_ctrl
  import io_pwr_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  io_pwr_seq_ctrl_if.master pwr
);
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LD = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
  logic pg_s;
  logic expired;
  logic up;
  pwr_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pad_ctrl_t pad_q, pad_d;
  io_pwr_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .d_i(pwr.pg_async),
    .q_o(pg_s)
  );
  function automatic logic [CNT_W-1:0] reload(pwr_state_e s);
    return s == WAIT_PG ? TMO_LD :
           s == DEBOUNCE ? DEB_LD :
           s inside {RET_REL, RX_EN, DRV_EN, SHUT_DRV, SHUT_RX} ? SET_LD : '0;
  endfunction
  assign expired = cnt_q == '0;
  assign up = state_q inside {RET_REL, RX_EN, DRV_EN, ON, SHUT_DRV, SHUT_RX};
  always_comb begin
    state_d = state_q;
    if (up && !pg_s) state_d = FAULT;
    else
      case (state_q)
        OFF:      state_d = pwr.req_on ? WAIT_PG : OFF;
        WAIT_PG:  state_d = !pwr.req_on ? OFF : pg_s ? DEBOUNCE : expired ? FAULT : WAIT_PG;
        DEBOUNCE: state_d = !pg_s ? WAIT_PG : !pwr.req_on ? OFF : expired ? RET_REL : DEBOUNCE;
        RET_REL:  state_d = !pwr.req_on ? SHUT_DRV : expired ? RX_EN : RET_REL;
        RX_EN:    state_d = !pwr.req_on ? SHUT_DRV : expired ? DRV_EN : RX_EN;
        DRV_EN:   state_d = !pwr.req_on ? SHUT_DRV : expired ? ON : DRV_EN;
        ON:       state_d = pwr.req_on ? ON : SHUT_DRV;
        SHUT_DRV: state_d = expired ? SHUT_RX : SHUT_DRV;
        SHUT_RX:  state_d = expired ? OFF : SHUT_RX;
        FAULT:    state_d = pwr.clr_fault ? OFF : FAULT;
        default:  state_d = OFF;
      endcase
    // every state entry reloads; otherwise count down and park at zero
    cnt_d = state_d != state_q ? reload(state_d) : expired ? '0 : cnt_q - 1'b1;
    pad_d = decode(state_d);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q <= '0;
      pad_q <= decode(OFF);
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pad_q <= pad_d;
    end
  assign pwr.io_ret = pad_q.ret;
  assign pwr.io_rx_en = pad_q.rx_en;
  assign pwr.io_drv_en = pad_q.drv_en;
  assign pwr.io_ready = pad_q.ready;
  assign pwr.fault = pad_q.fault;
  assign pwr.state_o = state_q;
endmodule

// File: tb/tb_io_pwr_seq_ctrl.sv
// tb_io_pwr_seq_ctrl: vector table plus randomized run against an elapsed-time reference model
module tb_io_pwr_seq_ctrl;
  localparam int SYNC = 2, DEB = 64, SETTLE = 16, TMO = 4096;
  localparam int P_OFF = 0, P_WAIT = 1, P_DEB = 2, P_RET = 3, P_RX = 4, P_DRV = 5,
                 P_ON = 6, P_SDRV = 7, P_SRX = 8, P_FAULT = 9;
  localparam logic [4:0] O_OFF = 5'b10000, O_RET = 5'b00000, O_RX = 5'b01000,
                         O_DRV = 5'b01100, O_ON = 5'b01110, O_FLT = 5'b10001;
  typedef struct {
    logic rst_n, pg, req, clr;
    int n;
    int st;
    logic [4:0] outs;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_ph = P_OFF;
  int m_el = 0;
  logic m_sh[SYNC];
  logic [4:0] out_of[10];
  vec_t vt[$];
  io_pwr_seq_ctrl_if pwr();
  io_pwr_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .pwr(pwr));
  always #5 clk = ~clk;
  function automatic logic [8:0] got();
    return {pwr.state_o, pwr.io_ret, pwr.io_rx_en, pwr.io_drv_en, pwr.io_ready, pwr.fault};
  endfunction
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: state/outs got=%h expected=%h", name, $time, act, exp);
    end
  endtask
  task automatic model_step();
    int nx, lim;
    logic pgs, done_;
    if (!rst_n) begin
      m_ph = P_OFF;
      m_el = 0;
      foreach (m_sh[i]) m_sh[i] = 1'b0;
      return;
    end
    pgs = m_sh[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = pwr.pg_async;
    lim = m_ph == P_WAIT ? TMO : m_ph == P_DEB ? DEB : SETTLE;
    done_ = m_el == lim - 1;
    if (m_ph >= P_RET && m_ph <= P_SRX && !pgs) nx = P_FAULT;
    else
      case (m_ph)
        P_OFF:  nx = pwr.req_on ? P_WAIT : P_OFF;
        P_WAIT: nx = !pwr.req_on ? P_OFF : pgs ? P_DEB : done_ ? P_FAULT : P_WAIT;
        P_DEB:  nx = !pgs ? P_WAIT : !pwr.req_on ? P_OFF : done_ ? P_RET : P_DEB;
        P_RET, P_RX, P_DRV: nx = !pwr.req_on ? P_SDRV : done_ ? m_ph + 1 : m_ph;
        P_ON:   nx = pwr.req_on ? P_ON : P_SDRV;
        P_SDRV: nx = done_ ? P_SRX : P_SDRV;
        P_SRX:  nx = done_ ? P_OFF : P_SRX;
        default: nx = pwr.clr_fault ? P_OFF : P_FAULT;
      endcase
    m_el = nx == m_ph ? m_el + 1 : 0;
    m_ph = nx;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model", got(), {4'(m_ph), out_of[m_ph]});
  endtask
  task automatic row(input logic r, input logic pg, input logic req, input logic clr,
                     input int n, input int st, input logic [4:0] outs);
    vt.push_back('{r, pg, req, clr, n, st, outs});
  endtask
  initial begin
    out_of = '{O_OFF, O_OFF, O_OFF, O_RET, O_RX, O_DRV, O_ON, O_RX, O_RET, O_FLT};
    foreach (m_sh[i]) m_sh[i] = 1'b0;
    pwr.pg_async = 1'b0;
    pwr.req_on = 1'b0;
    pwr.clr_fault = 1'b0;
    row(0,0,0,0,2,P_OFF,O_OFF);    row(1,1,0,0,5,P_OFF,O_OFF);
    row(1,1,1,0,1,P_WAIT,O_OFF);   row(1,1,1,0,1,P_DEB,O_OFF);
    row(1,1,1,0,63,P_DEB,O_OFF);   row(1,1,1,0,1,P_RET,O_RET);
    row(1,1,1,0,15,P_RET,O_RET);   row(1,1,1,0,1,P_RX,O_RX);
    row(1,1,1,0,15,P_RX,O_RX);     row(1,1,1,0,1,P_DRV,O_DRV);
    row(1,1,1,0,15,P_DRV,O_DRV);   row(1,1,1,0,1,P_ON,O_ON);
    row(1,1,1,0,20,P_ON,O_ON);     row(1,1,0,0,1,P_SDRV,O_RX);
    row(1,1,0,0,15,P_SDRV,O_RX);   row(1,1,0,0,1,P_SRX,O_RET);
    row(1,1,0,0,15,P_SRX,O_RET);   row(1,1,0,0,1,P_OFF,O_OFF);
    row(1,1,1,1,1,P_WAIT,O_OFF);   row(1,1,1,0,1,P_DEB,O_OFF);
    row(1,1,1,0,23,P_DEB,O_OFF);   row(1,0,1,0,3,P_WAIT,O_OFF);
    row(1,1,1,0,2,P_WAIT,O_OFF);   row(1,1,1,0,1,P_DEB,O_OFF);
    row(1,1,1,0,63,P_DEB,O_OFF);   row(1,1,1,0,1,P_RET,O_RET);
    row(1,1,1,0,15,P_RET,O_RET);   row(1,1,1,0,1,P_RX,O_RX);
    row(1,1,1,0,15,P_RX,O_RX);     row(1,1,1,0,1,P_DRV,O_DRV);
    row(1,1,1,0,15,P_DRV,O_DRV);   row(1,1,1,0,1,P_ON,O_ON);
    row(1,0,1,0,2,P_ON,O_ON);      row(1,0,1,0,1,P_FAULT,O_FLT);
    row(1,0,1,0,5,P_FAULT,O_FLT);  row(1,0,1,1,1,P_OFF,O_OFF);
    row(1,0,1,0,1,P_WAIT,O_OFF);   row(1,0,1,0,4095,P_WAIT,O_OFF);
    row(1,0,1,0,1,P_FAULT,O_FLT);  row(1,0,0,1,1,P_OFF,O_OFF);
    row(1,1,0,0,3,P_OFF,O_OFF);    row(1,1,1,0,1,P_WAIT,O_OFF);
    row(1,1,1,0,1,P_DEB,O_OFF);    row(1,1,1,0,63,P_DEB,O_OFF);
    row(1,1,1,0,1,P_RET,O_RET);    row(1,1,0,0,1,P_SDRV,O_RX);
    row(1,1,0,0,15,P_SDRV,O_RX);   row(1,1,0,0,1,P_SRX,O_RET);
    row(1,1,1,0,15,P_SRX,O_RET);   row(1,1,1,0,1,P_OFF,O_OFF);
    row(1,1,1,0,1,P_WAIT,O_OFF);   row(1,1,1,0,1,P_DEB,O_OFF);
    row(1,1,0,0,1,P_OFF,O_OFF);    row(1,1,1,0,1,P_WAIT,O_OFF);
    row(1,1,1,0,1,P_DEB,O_OFF);    row(1,1,1,0,64,P_RET,O_RET);
    row(1,1,1,0,16,P_RX,O_RX);     row(1,1,1,0,5,P_RX,O_RX);
    row(0,1,1,0,1,P_OFF,O_OFF);    row(1,1,1,0,1,P_WAIT,O_OFF);
    row(1,1,1,0,1,P_WAIT,O_OFF);   row(1,1,1,0,1,P_DEB,O_OFF);
    foreach (vt[k]) begin
      rst_n = vt[k].rst_n;
      pwr.pg_async = vt[k].pg;
      pwr.req_on = vt[k].req;
      pwr.clr_fault = vt[k].clr;
      for (int c = 0; c < vt[k].n; c++) cyc();
      check($sformatf("row%0d", k), got(), {4'(vt[k].st), vt[k].outs});
    end
    for (int c = 0; c < 20000; c++) begin
      rst_n = $urandom_range(0, 2999) != 0;
      if ($urandom_range(0, 299) == 0) pwr.pg_async = ~pwr.pg_async;
      if ($urandom_range(0, 199) == 0) pwr.req_on = ~pwr.req_on;
      pwr.clr_fault = $urandom_range(0, 39) == 0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
